gate_mux_scheduler: RTL and testbench

- Time-shares one external combinational gate bank (inverter/AND/OR slices, W bits wide) among N_REQ requesters.
- Each request is a W-bit 2:1 mux operation: result = s ? y : x.
- The block arbitrates requesters round-robin, captures the winner's operands, and drives the gate bank through a fixed four-step sequence: NOT, AND, AND, OR.
- It returns the result with a done pulse and the requester index.

---
 rtl/gate_mux_scheduler_if.sv | 31 +++
 rtl/gate_mux_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_gate_mux_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_mux_scheduler_if.sv
// Bus bundle between the mux scheduler, its requesters and the shared gate bank.
// The scheduler takes the slave view; the requester/gate-bank side takes the master view.
interface gate_mux_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] x_in;
   logic [N_REQ*W-1:0] y_in;
   logic [N_REQ-1:0]   s_in;
   logic [N_REQ-1:0]   gnt;
   logic               busy;
   logic [1:0]         gate_op;
   logic [W-1:0]       gate_a;
   logic [W-1:0]       gate_b;
   logic [W-1:0]       gate_y;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic [W-1:0]       result;

   modport slave (
      input  req, x_in, y_in, s_in, gate_y,
      output gnt, busy, gate_op, gate_a, gate_b, done, done_id, result
   );

   modport master (
      output req, x_in, y_in, s_in, gate_y,
      input  gnt, busy, gate_op, gate_a, gate_b, done, done_id, result
   );
endinterface

// File: rtl/gate_mux_scheduler.sv
// Round-robin scheduler that time-shares one external bitwise gate bank to
// evaluate result = s ? y : x for N_REQ requesters as (~srep & x) | (srep & y).
// Gate bank controls are registered one cycle ahead of the state they belong to,
// so the gate bank sees only flop outputs. The "ns" and "t1" temporaries live
// directly in the gate_a / gate_b flops because they are consumed in the very
// next step; only t0 needs its own flop.
module gate_mux_scheduler #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   gate_mux_scheduler_if.slave   bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_NOT  = 3'd1,
      S_ANDX = 3'd2,
      S_ANDY = 3'd3,
      S_OR   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   done_id_q, done_id_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d, srep_q, srep_d, t0_q, t0_d;
   logic [W-1:0]     result_q, result_d;
   logic [W-1:0]     gate_a_q, gate_a_d, gate_b_q, gate_b_d;
   logic [1:0]       gate_op_q, gate_op_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             done_q, done_d, busy_q, busy_d;

   logic             found_s;
   logic [IDW-1:0]   pick_s;
   logic [IDW-1:0]   cand_s;
   logic [W-1:0]     x_sel_s, y_sel_s;
   logic             s_sel_s;
   logic [N_REQ-1:0] onehot_s;

   // Round-robin pick: first requester above the last winner, wrapping around.
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      cand_s  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_s = IDW'((int'(rr_q) + k) % N_REQ);
         if (!found_s && bus.req[cand_s]) begin
            found_s = 1'b1;
            pick_s  = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Operand and grant selection for the picked requester.
   always_comb begin
      x_sel_s  = '0;
      y_sel_s  = '0;
      s_sel_s  = 1'b0;
      onehot_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_s == IDW'(i)) begin
            x_sel_s     = bus.x_in[i*W +: W];
            y_sel_s     = bus.y_in[i*W +: W];
            s_sel_s     = bus.s_in[i];
            onehot_s[i] = 1'b1;
         end else begin
            onehot_s[i] = 1'b0;
         end
      end
   end

   // Next-state, operand capture and next-cycle gate bank controls.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      done_id_d = done_id_q;
      x_d       = x_q;
      y_d       = y_q;
      srep_d    = srep_q;
      t0_d      = t0_q;
      result_d  = result_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      gate_op_d = 2'b00;
      gate_a_d  = '0;
      gate_b_d  = '0;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d   = S_NOT;
               rr_d      = pick_s;
               done_id_d = pick_s;
               x_d       = x_sel_s;
               y_d       = y_sel_s;
               srep_d    = {W{s_sel_s}};
               gnt_d     = onehot_s;
               gate_op_d = 2'b01;
               gate_a_d  = {W{s_sel_s}};
               gate_b_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         S_NOT: begin
            // gate_y is ~srep here; it becomes operand a of the x-side AND.
            state_d   = S_ANDX;
            gate_op_d = 2'b10;
            gate_a_d  = bus.gate_y;
            gate_b_d  = x_q;
         end
         S_ANDX: begin
            state_d   = S_ANDY;
            t0_d      = bus.gate_y;
            gate_op_d = 2'b10;
            gate_a_d  = srep_q;
            gate_b_d  = y_q;
         end
         S_ANDY: begin
            // gate_y is srep & y here; it becomes operand b of the final OR.
            state_d   = S_OR;
            gate_op_d = 2'b11;
            gate_a_d  = t0_q;
            gate_b_d  = bus.gate_y;
         end
         S_OR: begin
            state_d  = DONE;
            result_d = bus.gate_y;
            done_d   = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         rr_q      <= IDW'(N_REQ - 1);
         done_id_q <= '0;
         x_q       <= '0;
         y_q       <= '0;
         srep_q    <= '0;
         t0_q      <= '0;
         result_q  <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         gate_op_q <= 2'b00;
         gate_a_q  <= '0;
         gate_b_q  <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         done_id_q <= done_id_d;
         x_q       <= x_d;
         y_q       <= y_d;
         srep_q    <= srep_d;
         t0_q      <= t0_d;
         result_q  <= result_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         gate_op_q <= gate_op_d;
         gate_a_q  <= gate_a_d;
         gate_b_q  <= gate_b_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.gate_op = gate_op_q;
   assign bus.gate_a  = gate_a_q;
   assign bus.gate_b  = gate_b_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.result  = result_q;
endmodule

// File: tb/tb_gate_mux_scheduler.sv
// Self-checking bench for gate_mux_scheduler: behavioural gate bank, a
// round-robin reference model and per-scenario tasks with inline checks.
module tb_gate_mux_scheduler;
   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   gate_mux_scheduler_if #(.N_REQ(N), .W(W), .IDW(IDW)) bus();

   gate_mux_scheduler #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   int model_rr;
   int last_gnt_cyc;
   logic         force_en = 1'b0;
   logic [W-1:0] force_val = 8'hFF;

   // Cycle counter used to measure grant spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural gate bank, optionally overridden by the bench.
   always_comb begin
      bus.gate_y = '0;
      if (force_en) begin
         bus.gate_y = force_val;
      end else begin
         case (bus.gate_op)
            2'b01:   bus.gate_y = ~bus.gate_a;
            2'b10:   bus.gate_y = bus.gate_a & bus.gate_b;
            2'b11:   bus.gate_y = bus.gate_a | bus.gate_b;
            default: bus.gate_y = '0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] mux_ref(input int i);
      logic [W-1:0] xv = bus.x_in[i*W +: W];
      logic [W-1:0] yv = bus.y_in[i*W +: W];
      return bus.s_in[i] ? yv : xv;
   endfunction

   // Reference arbiter: first requester after the last winner, with wrap.
   function automatic int model_pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(model_rr + k) % N]) return (model_rr + k) % N;
      end
      return -1;
   endfunction

   task automatic randomize_ops();
      for (int i = 0; i < N; i++) begin
         bus.x_in[i*W +: W] = W'($urandom);
         bus.y_in[i*W +: W] = W'($urandom);
      end
      bus.s_in = N'($urandom);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 10 && bus.busy; n++) tick();
   endtask

   // One transaction from an idle scheduler; checks grant, latency and result.
   task automatic run_txn(input logic [N-1:0] r, input bit hold);
      int exp_id;
      bit got;
      logic [W-1:0] exp_res;
      logic [N-1:0] one;
      exp_id = model_pick(r);
      one = {{(N-1){1'b0}}, 1'b1};
      bus.req = r;
      got = 1'b0;
      for (int n = 0; n < 12 && !got; n++) begin
         tick();
         if (bus.gnt != '0) got = 1'b1;
      end
      vecs++;
      if (!got || bus.gnt !== (one << exp_id)) begin
         errs++;
         $display("FAIL txn_gnt: got %b want %b (req %b)", bus.gnt, one << exp_id, r);
         bus.req = '0;
         return;
      end
      last_gnt_cyc = cyc;
      exp_res = mux_ref(exp_id);
      model_rr = exp_id;
      if (!hold) bus.req = '0;
      randomize_ops();
      repeat (4) tick();
      vecs++;
      if (bus.done !== 1'b1 || bus.done_id !== IDW'(exp_id) || bus.result !== exp_res) begin
         errs++;
         $display("FAIL txn_done: got done=%b id=%0d res=%h want done=1 id=%0d res=%h",
                  bus.done, bus.done_id, bus.result, exp_id, exp_res);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.req = '0;
      bus.x_in = '0;
      bus.y_in = '0;
      bus.s_in = '0;
      #12;
      vecs++;
      if ({bus.gnt, bus.busy, bus.gate_op, bus.gate_a, bus.gate_b,
           bus.done, bus.done_id, bus.result} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got gnt=%b busy=%b op=%b a=%h b=%h done=%b id=%0d res=%h want all 0",
                  bus.gnt, bus.busy, bus.gate_op, bus.gate_a, bus.gate_b,
                  bus.done, bus.done_id, bus.result);
      end
      tick();
      resetn = 1'b1;
      model_rr = N - 1;
      tick();
      vecs++;
      if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
         errs++;
         $display("FAIL idle_no_req: got busy=%b gnt=%b want 0", bus.busy, bus.gnt);
      end
   endtask

   // Cycle-accurate walk of one operation, including the gate bank operands.
   task automatic test_cycle_detail(input int idx, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input logic s, input bit frc);
      logic [1:0]   eop [1:4];
      logic [W-1:0] ea  [1:4];
      logic [W-1:0] eb  [1:4];
      logic [W-1:0] srep;
      logic [W-1:0] exp_res;
      logic [N-1:0] one;
      one = {{(N-1){1'b0}}, 1'b1};
      srep = {W{s}};
      eop[1] = 2'b01; ea[1] = srep;         eb[1] = '0;
      eop[2] = 2'b10; ea[2] = ~srep;        eb[2] = x;
      eop[3] = 2'b10; ea[3] = srep;         eb[3] = y;
      eop[4] = 2'b11; ea[4] = x & ~srep;    eb[4] = y & srep;
      exp_res = frc ? force_val : (s ? y : x);
      wait_idle();
      bus.x_in[idx*W +: W] = x;
      bus.y_in[idx*W +: W] = y;
      bus.s_in[idx] = s;
      bus.req = one << idx;
      tick();
      vecs++;
      if (bus.gnt !== (one << idx) || bus.busy !== 1'b1) begin
         errs++;
         $display("FAIL detail_gnt: got gnt=%b busy=%b want gnt=%b busy=1", bus.gnt, bus.busy, one << idx);
      end
      bus.req = '0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4 && frc) force_en = 1'b1;
         vecs++;
         if (bus.gate_op !== eop[c] || bus.gate_a !== ea[c] || bus.gate_b !== eb[c]) begin
            errs++;
            $display("FAIL gate_step%0d: got op=%b a=%h b=%h want op=%b a=%h b=%h",
                     c, bus.gate_op, bus.gate_a, bus.gate_b, eop[c], ea[c], eb[c]);
         end
         tick();
      end
      force_en = 1'b0;
      vecs++;
      if (bus.done !== 1'b1 || bus.done_id !== IDW'(idx) || bus.result !== exp_res ||
          bus.gate_op !== 2'b00) begin
         errs++;
         $display("FAIL detail_done: got done=%b id=%0d res=%h op=%b want done=1 id=%0d res=%h op=00",
                  bus.done, bus.done_id, bus.result, bus.gate_op, idx, exp_res);
      end
      tick();
      vecs++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_res) begin
         errs++;
         $display("FAIL detail_after: got done=%b busy=%b res=%h want done=0 busy=0 res=%h",
                  bus.done, bus.busy, bus.result, exp_res);
      end
      model_rr = idx;
   endtask

   task automatic test_round_robin();
      int prev;
      randomize_ops();
      wait_idle();
      prev = -1;
      for (int g = 0; g < 5; g++) begin
         run_txn(4'b1111, 1'b1);
         vecs++;
         if (model_rr !== g % N) begin
            errs++;
            $display("FAIL rr_order: got %0d want %0d", model_rr, g % N);
         end
         if (g > 0) begin
            vecs++;
            if (last_gnt_cyc - prev !== 6) begin
               errs++;
               $display("FAIL rr_spacing: got %0d want 6", last_gnt_cyc - prev);
            end
         end
         prev = last_gnt_cyc;
      end
      bus.req = '0;
   endtask

   task automatic test_wrap();
      wait_idle();
      run_txn(4'b1000, 1'b0);
      run_txn(4'b1001, 1'b0);
      run_txn(4'b0010, 1'b0);
      run_txn(4'b0110, 1'b0);
   endtask

   task automatic test_gate_probe();
      test_cycle_detail(int'($urandom_range(0, N - 1)), W'($urandom), W'($urandom),
                        1'($urandom), 1'b1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         randomize_ops();
         run_txn(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
      end
   endtask

   task automatic test_withdraw_busy();
      int ngnt, ndone;
      logic [W-1:0] exp_res;
      bit got;
      wait_idle();
      tick();
      randomize_ops();
      model_rr = 0;
      bus.req = 4'b0001;
      got = 1'b0;
      for (int n = 0; n < 12 && !got; n++) begin
         tick();
         if (bus.gnt != '0) got = 1'b1;
      end
      vecs++;
      if (bus.gnt !== 4'b0001) begin
         errs++;
         $display("FAIL wd_first_gnt: got %b want 0001", bus.gnt);
      end
      exp_res = mux_ref(0);
      ngnt = 0;
      ndone = 0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 1) bus.req = 4'b0000;
         if (c == 2) bus.req = 4'b0010;
         if (c == 3) bus.req = 4'b0001;
         if (c == 5) bus.req = 4'b0000;
         tick();
         if (bus.gnt != '0) ngnt++;
         if (bus.done) ndone++;
      end
      vecs++;
      if (ngnt !== 0 || ndone !== 1 || bus.done_id !== 2'd0 || bus.result !== exp_res) begin
         errs++;
         $display("FAIL withdraw_busy: got gnts=%0d dones=%0d id=%0d res=%h want 0 1 0 %h",
                  ngnt, ndone, bus.done_id, bus.result, exp_res);
      end
   endtask

   task automatic test_reset_midop();
      int ndone;
      wait_idle();
      randomize_ops();
      bus.req = 4'b0100;
      tick();
      vecs++;
      if (bus.gnt !== 4'b0100) begin
         errs++;
         $display("FAIL midop_gnt: got %b want 0100", bus.gnt);
      end
      bus.req = '0;
      tick();
      tick();
      resetn = 1'b0;
      #1;
      vecs++;
      if ({bus.gnt, bus.busy, bus.gate_op, bus.gate_a, bus.gate_b,
           bus.done, bus.done_id, bus.result} !== '0) begin
         errs++;
         $display("FAIL midop_async_clear: got busy=%b op=%b a=%h b=%h done=%b id=%0d res=%h want all 0",
                  bus.busy, bus.gate_op, bus.gate_a, bus.gate_b, bus.done, bus.done_id, bus.result);
      end
      ndone = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.done) ndone++;
      end
      resetn = 1'b1;
      model_rr = N - 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.done) ndone++;
      end
      vecs++;
      if (ndone !== 0 || bus.result !== '0) begin
         errs++;
         $display("FAIL midop_no_done: got dones=%0d res=%h want 0 00", ndone, bus.result);
      end
      run_txn(4'b0001, 1'b0);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_cycle_detail(0, 8'hA5, 8'h3C, 1'b0, 1'b0);
      test_cycle_detail(0, 8'hA5, 8'h3C, 1'b1, 1'b0);
      test_wrap();
      test_gate_probe();
      test_random();
      test_withdraw_busy();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
